imem_loader: RTL

Boot-time sequencer for the writable instruction memory of the single-cycle RISC-V core. Receives a little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words and writes them to consecutive word addresses. Holds the core in reset (`core_hold`) until a complete program has been loaded. Sits between the external byte source (UART receiver or testbench) and the instruction memory write port, ahead of the fetch path.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_loader_word_packer.sv | 37 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRecv,
      StWrite,
      StFinish
   } state_e;

   // Contents of unwritten instruction-memory words.
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   function automatic int unsigned word_cap(input int unsigned addr_w);
      return 32'd1 << (addr_w - 2);
   endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; byte k lands at bits [8k+7:8k].
module word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        strobe,
   input  logic [7:0]  data,
   output logic [31:0] word,
   output logic        full
);

   logic [1:0]  idx_q;
   logic [31:0] word_q;

   // word/full reflect the byte being strobed this cycle, so the caller can
   // capture a completed word on the same edge that accepts its last byte.
   always_comb begin
      word = word_q;
      if (strobe) begin
         word[{idx_q, 3'b000} +: 8] = data;
      end
      full = strobe && (idx_q == 2'd3);
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         idx_q  <= 2'd0;
         word_q <= NOP_WORD;
      end else if (strobe) begin
         idx_q  <= idx_q + 2'd1;
         word_q <= full ? NOP_WORD : word;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: streams bytes into instruction memory and holds the core
// in reset until a complete program has been written.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned LEN_W   = ADDR_W - 1,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned WORDS  = word_cap(ADDR_W);
   localparam int unsigned CNT_W  = ADDR_W - 1;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   state_e              state_q;
   logic [CNT_W-1:0]    len_q;
   logic [CNT_W-1:0]    word_cnt_q;
   logic [CNT_W-1:0]    word_cnt_inc;
   logic [IDLE_W-1:0]   idle_q;
   logic                hs;
   logic                timeout;
   logic                pk_clear;
   logic                pk_full;
   logic [31:0]         pk_word;

   assign hs           = s_valid & s_ready;
   assign timeout      = (state_q == StRecv) && !hs && (idle_q == IDLE_W'(TIMEOUT - 1));
   assign pk_clear     = ((state_q == StIdle) && start) || timeout;
   assign word_cnt_inc = word_cnt_q + CNT_W'(1);

   word_packer u_packer (
      .clk    (clk),
      .rst    (rst),
      .clear  (pk_clear),
      .strobe (hs),
      .data   (s_data),
      .word   (pk_word),
      .full   (pk_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         len_q      <= '0;
         word_cnt_q <= '0;
         idle_q     <= '0;
         s_ready    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= NOP_WORD;
         core_hold  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  err        <= 1'b0;
                  word_cnt_q <= '0;
                  idle_q     <= '0;
                  if (len != '0) begin
                     len_q     <= (32'(len) > WORDS) ? CNT_W'(WORDS) : CNT_W'(len);
                     core_hold <= 1'b1;
                     busy      <= 1'b1;
                     s_ready   <= 1'b1;
                     state_q   <= StRecv;
                  end else begin
                     done      <= 1'b1;
                     core_hold <= 1'b0;
                     busy      <= 1'b0;
                     state_q   <= StFinish;
                  end
               end
            end
            StRecv: begin
               if (hs) begin
                  idle_q <= '0;
                  if (pk_full) begin
                     s_ready   <= 1'b0;
                     mem_we    <= 1'b1;
                     mem_addr  <= {word_cnt_q[ADDR_W-3:0], 2'b00};
                     mem_wdata <= pk_word;
                     state_q   <= StWrite;
                  end
               end else if (timeout) begin
                  // Abort: partial word is dropped and the core stays held.
                  err     <= 1'b1;
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  idle_q <= idle_q + IDLE_W'(1);
               end
            end
            StWrite: begin
               word_cnt_q <= word_cnt_inc;
               if (word_cnt_inc == len_q) begin
                  done      <= 1'b1;
                  core_hold <= 1'b0;
                  busy      <= 1'b0;
                  state_q   <= StFinish;
               end else begin
                  s_ready <= 1'b1;
                  state_q <= StRecv;
               end
            end
            StFinish: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
